// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch encodings, width default and direction helpers
package branch_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } funct3_e;

   function automatic logic f3_is_legal(input logic [2:0] f3);
      return (f3 != 3'b010) && (f3 != 3'b011);
   endfunction

   // Unsupported encodings resolve not-taken so mispredict tracks the prediction.
   function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                         input logic lt_s, input logic lt_u);
      logic t;
      t = 1'b0;
      case (funct3_e'(f3))
         F3_BEQ:  t = eq;
         F3_BNE:  t = !eq;
         F3_BLT:  t = lt_s;
         F3_BGE:  t = !lt_s;
         F3_BLTU: t = lt_u;
         F3_BGEU: t = !lt_u;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational equal / signed-less / unsigned-less comparator
module branch_cmp #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            eq_o,
   output logic            lt_s_o,
   output logic            lt_u_o
);

   assign eq_o   = (a_i == b_i);
   assign lt_s_o = ($signed(a_i) < $signed(b_i));
   assign lt_u_o = (a_i < b_i);

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch resolve stage; BRANCH_RESOLVE_STATS_EN adds branch/mispredict counters
module branch_resolve
   import branch_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic            pred_taken_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic            taken_o,
   output logic [XLEN-1:0] target_o,
   output logic            mispredict_o,
   output logic            illegal_o
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [31:0]     stat_branches_o,
   output logic [31:0]     stat_mispredicts_o
`endif
);

   logic            w_eq;
   logic            w_lt_s;
   logic            w_lt_u;
   logic            w_taken;
   logic            w_illegal;
   logic [XLEN-1:0] w_target;
   logic            w_accept;
   logic            w_out_hs;

   logic            r_valid;
   logic            r_taken;
   logic [XLEN-1:0] r_target;
   logic            r_mispredict;
   logic            r_illegal;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .a_i    (rs1_i),
      .b_i    (rs2_i),
      .eq_o   (w_eq),
      .lt_s_o (w_lt_s),
      .lt_u_o (w_lt_u)
   );

   assign w_illegal = !f3_is_legal(funct3_i);
   assign w_taken   = branch_taken(funct3_i, w_eq, w_lt_s, w_lt_u);
   assign w_target  = pc_i + imm_i;

   assign in_ready_o = !r_valid || out_ready_i;
   assign w_accept   = in_valid_i && in_ready_o && !flush_i;
   assign w_out_hs   = r_valid && out_ready_i;

   // Flush outranks both handshakes: the held result and any incoming request are dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid      <= 1'b0;
         r_taken      <= 1'b0;
         r_target     <= '0;
         r_mispredict <= 1'b0;
         r_illegal    <= 1'b0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid      <= 1'b1;
         r_taken      <= w_taken;
         r_target     <= w_target;
         r_mispredict <= w_taken ^ pred_taken_i;
         r_illegal    <= w_illegal;
      end else if (w_out_hs) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid_o  = r_valid;
   assign taken_o      = r_taken;
   assign target_o     = r_target;
   assign mispredict_o = r_mispredict;
   assign illegal_o    = r_illegal;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   // Only legal branches leaving the stage are counted; flushed results never count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
      end else if (w_out_hs && !flush_i && !r_illegal) begin
         r_stat_branches <= r_stat_branches + 32'd1;
         if (r_mispredict)
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
   end

   assign stat_branches_o    = r_stat_branches;
   assign stat_mispredicts_o = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - vector-table and sequence bench for branch_resolve
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] pc = '0;
   logic [31:0] imm = '0;
   logic        pred = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        taken;
   logic [31:0] target;
   logic        misp;
   logic        illegal;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] stat_br;
   logic [31:0] stat_mp;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   branch_resolve #(.XLEN(32)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .rs1_i        (rs1),
      .rs2_i        (rs2),
      .funct3_i     (funct3),
      .pc_i         (pc),
      .imm_i        (imm),
      .pred_taken_i (pred),
      .flush_i      (flush),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .taken_o      (taken),
      .target_o     (target),
      .mispredict_o (misp),
      .illegal_o    (illegal)
`ifdef BRANCH_RESOLVE_STATS_EN
      ,
      .stat_branches_o    (stat_br),
      .stat_mispredicts_o (stat_mp)
`endif
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        pred;
      logic        tk;
      logic        mp;
      logic        il;
      logic [31:0] tgt;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i, input logic pr);
      funct3 = f; rs1 = a; rs2 = b; pc = p; imm = i; pred = pr;
   endtask

   int exp_br = 0;
   int exp_mp = 0;

   initial begin
      vt[0]  = '{3'b000, 32'd5,        32'd5,        32'h0000_1000, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1008};
      vt[1]  = '{3'b001, 32'd5,        32'd5,        32'h0000_1000, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1008};
      vt[2]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_2000, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2010};
      vt[3]  = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_2000, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2010};
      vt[4]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_2000, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2010};
      vt[5]  = '{3'b101, 32'h8000_0000, 32'h0000_0001, 32'h0000_3000, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3004};
      vt[6]  = '{3'b100, 32'h8000_0000, 32'h0000_0001, 32'h0000_3000, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3004};
      vt[7]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h0000_3000, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3004};
      vt[8]  = '{3'b000, 32'd0,        32'd0,        32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010};
      vt[9]  = '{3'b010, 32'd1,        32'd1,        32'h0000_0100, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00FC};
      vt[10] = '{3'b011, 32'd1,        32'd2,        32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
      vt[11] = '{3'b101, 32'd7,        32'd7,        32'h0000_4000, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_4100};

      // Reset state
      in_valid = 1'b1;
      drive(3'b000, 32'd1, 32'd1, 32'h10, 32'h10, 1'b0);
      step(); step();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_taken", {31'd0, taken}, 32'd0);
      chk("rst_target", target, 32'd0);
      chk("rst_misp", {31'd0, misp}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("rst_stat_br", stat_br, 32'd0);
      chk("rst_stat_mp", stat_mp, 32'd0);
`endif
      in_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

      // Table: back-to-back at full throughput
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(vt[i].f3, vt[i].a, vt[i].b, vt[i].pc, vt[i].imm, vt[i].pred);
         step();
         chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d_taken", i), {31'd0, taken}, {31'd0, vt[i].tk});
         chk($sformatf("v%0d_misp", i), {31'd0, misp}, {31'd0, vt[i].mp});
         chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vt[i].il});
         chk($sformatf("v%0d_target", i), target, vt[i].tgt);
         if (!vt[i].il) begin
            exp_br++;
            if (vt[i].mp) exp_mp++;
         end
      end
      in_valid = 1'b0;
      step();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("table_stat_br", stat_br, exp_br);
      chk("table_stat_mp", stat_mp, exp_mp);
`endif

      // Backpressure: A held for 3 cycles while B waits, then B and C one per cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(3'b000, 32'd9, 32'd9, 32'h0000_0A00, 32'h0000_0004, 1'b0);
      step();
      chk("bp_a_valid", {31'd0, out_valid}, 32'd1);
      drive(3'b001, 32'd1, 32'd2, 32'h0000_0B00, 32'h0000_0008, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp_ready_%0d", k), {31'd0, in_ready}, 32'd0);
         step();
         chk($sformatf("bp_hold_valid_%0d", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp_hold_target_%0d", k), target, 32'h0000_0A04);
         chk($sformatf("bp_hold_misp_%0d", k), {31'd0, misp}, 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("bp_b_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_b_target", target, 32'h0000_0B08);
      chk("bp_b_taken", {31'd0, taken}, 32'd1);
      drive(3'b110, 32'd3, 32'd2, 32'h0000_0C00, 32'h0000_0010, 1'b1);
      step();
      chk("bp_c_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_c_target", target, 32'h0000_0C10);
      chk("bp_c_misp", {31'd0, misp}, 32'd1);
      in_valid = 1'b0;
      step();
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
      exp_br += 3;
      exp_mp += 3;
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("bp_stat_br", stat_br, exp_br);
      chk("bp_stat_mp", stat_mp, exp_mp);
`endif

      // Flush while a result is held and a new request is offered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(3'b000, 32'd4, 32'd4, 32'h0000_0D00, 32'h0000_0004, 1'b0);
      step();
      chk("fl_d_valid", {31'd0, out_valid}, 32'd1);
      drive(3'b001, 32'd4, 32'd5, 32'h0000_0E00, 32'h0000_0004, 1'b0);
      flush = 1'b1;
      step();
      chk("fl_valid_cleared", {31'd0, out_valid}, 32'd0);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("fl_e_dropped", {31'd0, out_valid}, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("fl_stat_br", stat_br, exp_br);
      chk("fl_stat_mp", stat_mp, exp_mp);
`endif

      // Reset mid-operation discards the held result
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(3'b000, 32'd2, 32'd2, 32'h0000_0F00, 32'h0000_0004, 1'b0);
      step();
      chk("mr_held_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      step();
      chk("mr_valid", {31'd0, out_valid}, 32'd0);
      chk("mr_target", target, 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;
      step();
      chk("mr_ready", {31'd0, in_ready}, 32'd1);
      chk("mr_valid_after", {31'd0, out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
